load_store_unit: RTL and testbench

//  Downstream of the ALU in the single-cycle core: takes the ALU result as effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit_align.sv | 50 +++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment legality rule used when a request is accepted.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // An access that cannot be expressed as a single aligned bus beat.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: byte enables and replicated store data for the bus,
// plus lane selection and sign/zero extension of returned read data.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be        = 4'b0000;
        wdata     = store_data;
        rdata_ext = rdata;
        byte_v    = rdata[{addr_lo, 3'b000} +: 8];
        half_v    = rdata[{addr_lo[1], 4'b0000} +: 16];

        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                rdata_ext = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                rdata_ext = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata     = store_data;
                rdata_ext = rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata     = store_data;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory bus transaction per load/store
// instruction, stalling the core until the access completes, aborts or faults.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       alu_addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign_err,
    output logic              bus_err,
    load_store_unit_if.master mem
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q;
    lsu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    mem_size_e        size_q;
    logic             we_q;
    logic             uns_q;

    logic             mis_q;
    logic             berr_q;

    logic             accept;
    logic             timeout_hit;
    logic             set_mis;
    logic             set_berr;
    logic             capture;
    logic             in_req;

    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rdata_ext;

    assign accept      = (state_q == IDLE) && req_valid;
    assign timeout_hit = (cnt_q >= CNT_LAST);

    always_comb begin
        state_d  = state_q;
        set_mis  = 1'b0;
        set_berr = 1'b0;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(mem_size_e'(req_size), alu_addr[1:0])) begin
                        state_d = RESP;
                        set_mis = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A grant wins over the timeout on the final counted cycle.
                if (mem.mem_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout_hit) begin
                    state_d  = RESP;
                    set_berr = 1'b1;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    state_d  = RESP;
                    set_berr = 1'b1;
                end
            end
            RESP: begin
                // req_valid is still the finished instruction here; never restart.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Error flags are registered so they line up with the RESP cycle (done).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            load_data <= '0;
        end else begin
            mis_q  <= set_mis;
            berr_q <= set_berr;
            if ((state_d == RESP) && (state_q != RESP)) begin
                load_data <= capture ? rdata_ext : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= alu_addr;
            data_q <= store_data;
            size_q <= mem_size_e'(req_size);
            we_q   <= req_we;
            uns_q  <= req_unsigned;
        end
    end

    load_store_unit_align u_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .store_data  (data_q),
        .rdata       (mem.mem_rdata),
        .be          (be),
        .wdata       (wdata),
        .rdata_ext   (rdata_ext)
    );

    // Bus outputs are only non-zero while a request is actually presented.
    assign in_req        = (state_q == REQ);
    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req & we_q;
    assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem.mem_be    = in_req ? be : 4'b0000;
    assign mem.mem_wdata = in_req ? wdata : '0;

    assign stall        = req_valid & (state_q != RESP) & ~rst;
    assign done         = (state_q == RESP);
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized loads/stores
// checked against a transaction-level reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] alu_addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit_if mif();

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .alu_addr     (alu_addr),
        .store_data   (store_data),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem          (mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [31:0] ld;
        logic        mis;
        logic        berr;
        logic        done_stall;
        logic        req_at_done;
        bit          stall_ok;
        bit          req_seen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return 4'(32'd1 << (addr % 4));
        if (size == 2'd1) return 4'(32'd3 << (addr & 32'd2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (size == 2'd1) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rdata >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Drives one request starting at posedge+1 with the DUT idle, acts as the
    // memory (grant after gd request cycles, rvalid rd cycles into WAIT) and
    // records what was observed. Returns at posedge+1 after the done cycle.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int gd, input int rd,
                           input bit drop, input bit collide, output obs_t o);
        int  gcnt;
        int  rcnt;
        bit  granted;
        o.lat = -1; o.ld = '0; o.mis = 1'b0; o.berr = 1'b0; o.done_stall = 1'b1;
        o.req_at_done = 1'b1; o.stall_ok = 1'b1; o.req_seen = 1'b0;
        o.addr = '0; o.wdata = '0; o.be = '0; o.we = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        alu_addr = addr; store_data = sdata;
        gcnt = gd; rcnt = 0; granted = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = $urandom;
            if (done) begin
                o.lat = n - 1; o.ld = load_data; o.mis = misalign_err; o.berr = bus_err;
                o.done_stall = stall; o.req_at_done = mif.mem_req;
                break;
            end
            if (req_valid && !stall) o.stall_ok = 1'b0;
            if (mif.mem_req && !o.req_seen) begin
                o.req_seen = 1'b1; o.addr = mif.mem_addr; o.wdata = mif.mem_wdata;
                o.be = mif.mem_be; o.we = mif.mem_we;
            end
            if (mif.mem_req) begin
                if (gcnt == 0) begin
                    mif.mem_gnt = 1'b1; granted = 1'b1; rcnt = rd;
                    if (collide) begin mif.mem_rvalid = 1'b1; mif.mem_rdata = ~rdata; end
                end else begin
                    gcnt--;
                end
            end else if (granted && !we) begin
                if (rcnt == 0) begin mif.mem_rvalid = 1'b1; mif.mem_rdata = rdata; end
                else rcnt--;
            end
            if (drop && n == 2) req_valid = 1'b0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        req_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({done, misalign_err, bus_err, mif.mem_req, mif.mem_we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000", {done, misalign_err, bus_err, mif.mem_req, mif.mem_we});
        end
        n_tests++;
        if ({mif.mem_addr, mif.mem_be, mif.mem_wdata, load_data} !== '0) begin
            n_fail++; $display("FAIL reset_data addr=%h be=%h wdata=%h ld=%h want all 0",
                               mif.mem_addr, mif.mem_be, mif.mem_wdata, load_data);
        end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_basic;
        obs_t o;
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hCAFE_BABE, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d want 3", o.lat); end
        n_tests++;
        if (o.ld !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL lw_data got %h want cafebabe", o.ld); end
        n_tests++;
        if ({o.be, o.addr, o.we} !== {4'hF, 32'h100, 1'b0}) begin
            n_fail++; $display("FAIL lw_bus be=%h addr=%h we=%b want f/00000100/0", o.be, o.addr, o.we);
        end
        n_tests++;
        if ({o.stall_ok, o.done_stall} !== 2'b10) begin
            n_fail++; $display("FAIL lw_stall ok=%b at_done=%b want 1/0", o.stall_ok, o.done_stall);
        end
    endtask

    task automatic test_load_ext;
        obs_t o;
        run_txn(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80FF_0000, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.ld !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext got %h want ffffff80", o.ld); end
        run_txn(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80FF_0000, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.ld !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext got %h want 00000080", o.ld); end
        run_txn(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h80FF_0000, 1, 2, 1'b0, 1'b0, o);
        n_tests++;
        if (o.ld !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_sext got %h want ffff80ff", o.ld); end
        n_tests++;
        if ({o.be, o.lat} !== {4'b1100, 32'd6}) begin
            n_fail++; $display("FAIL lh_be_lat be=%b lat=%0d want 1100/6", o.be, o.lat);
        end
    endtask

    task automatic test_store;
        obs_t o;
        run_txn(1'b1, 2'd0, 1'b0, 32'h301, 32'h1234_56AB, 32'h0, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if ({o.addr, o.be, o.we} !== {32'h300, 4'b0010, 1'b1}) begin
            n_fail++; $display("FAIL sb_bus addr=%h be=%b we=%b want 00000300/0010/1", o.addr, o.be, o.we);
        end
        n_tests++;
        if (o.wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got %h want abababab", o.wdata); end
        n_tests++;
        if (o.lat !== 2) begin n_fail++; $display("FAIL sb_latency got %0d want 2", o.lat); end
    endtask

    task automatic test_misalign;
        obs_t o;
        logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ad [3] = '{32'h102, 32'h101, 32'h200};
        for (int i = 0; i < 3; i++) begin
            run_txn(i == 1, sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, 32'h5555_5555, 0, 0, 1'b0, 1'b0, o);
            n_tests++;
            if ({o.lat, o.mis, o.berr, o.req_seen, o.ld} !== {32'd1, 1'b1, 1'b0, 1'b0, 32'h0}) begin
                n_fail++; $display("FAIL misalign_%0d lat=%0d mis=%b berr=%b req=%b ld=%h want 1/1/0/0/0",
                                   i, o.lat, o.mis, o.berr, o.req_seen, o.ld);
            end
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_txn(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h1111_2222, 1000, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.lat !== TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_lat got %0d want %0d", o.lat, TIMEOUT + 1); end
        n_tests++;
        if ({o.berr, o.mis, o.req_at_done, o.ld} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL timeout_flags berr=%b mis=%b req=%b ld=%h want 1/0/0/0",
                               o.berr, o.mis, o.req_at_done, o.ld);
        end
        run_txn(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 32'h3333_4444, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if ({o.lat, o.ld, o.berr} !== {32'd3, 32'h3333_4444, 1'b0}) begin
            n_fail++; $display("FAIL timeout_next lat=%0d ld=%h berr=%b want 3/33334444/0", o.lat, o.ld, o.berr);
        end
    endtask

    task automatic test_collide_drop;
        obs_t o;
        run_txn(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b0, 1'b1, o);
        n_tests++;
        if ({o.lat, o.ld} !== {32'd4, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL gnt_rvalid_collide lat=%0d ld=%h want 4/0badf00d", o.lat, o.ld);
        end
        run_txn(1'b0, 2'd2, 1'b0, 32'h604, 32'h0, 32'h1357_9BDF, 2, 1, 1'b1, 1'b0, o);
        n_tests++;
        if ({o.lat, o.ld} !== {32'd6, 32'h1357_9BDF}) begin
            n_fail++; $display("FAIL req_drop lat=%0d ld=%h want 6/13579bdf", o.lat, o.ld);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        bit   saw_done;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; alu_addr = 32'h700;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; #1;
        n_tests++;
        if ({mif.mem_req, done, stall} !== 3'b000) begin
            n_fail++; $display("FAIL rst_in_req req=%b done=%b stall=%b want 000", mif.mem_req, done, stall);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk); mif.mem_gnt = 1'b1;
        @(negedge clk); mif.mem_gnt = 1'b0;
        rst = 1'b1; #1;
        n_tests++;
        if ({mif.mem_req, done, stall, mif.mem_be, mif.mem_addr, load_data} !== '0) begin
            n_fail++; $display("FAIL rst_in_wait req=%b done=%b stall=%b be=%h addr=%h ld=%h want 0",
                               mif.mem_req, done, stall, mif.mem_be, mif.mem_addr, load_data);
        end
        req_valid = 1'b0; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); rst = 1'b0; mif.mem_rvalid = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done got done pulse want none"); end
        @(posedge clk); #1;
        run_txn(1'b0, 2'd1, 1'b1, 32'h706, 32'h0, 32'h8001_7FFE, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if ({o.lat, o.ld} !== {32'd3, 32'h0000_8001}) begin
            n_fail++; $display("FAIL rst_then_load lat=%0d ld=%h want 3/00008001", o.lat, o.ld);
        end
    endtask

    task automatic test_random;
        obs_t        o;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        bit          drop;
        bit          col;
        bit          mis;
        int          exp_lat;
        for (int t = 0; t < 150; t++) begin
            we    = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns   = 1'($urandom_range(0, 1));
            addr  = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & ~((size == 2'd2) ? 32'd3 : (size == 2'd1) ? 32'd1 : 32'd0);
            sdata = $urandom;
            rdata = $urandom;
            gd    = int'($urandom_range(0, 3));
            rd    = int'($urandom_range(0, 3));
            drop  = ($urandom_range(0, 7) == 0);
            col   = ($urandom_range(0, 3) == 0);
            mis   = m_mis(size, addr);
            exp_lat = mis ? 1 : (we ? gd + 2 : gd + rd + 3);
            run_txn(we, size, uns, addr, sdata, rdata, gd, rd, drop, col, o);
            n_tests++;
            if (o.lat !== exp_lat) begin
                n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", t, o.lat, exp_lat);
            end
            n_tests++;
            if ({o.mis, o.berr} !== {mis, 1'b0}) begin
                n_fail++; $display("FAIL rnd%0d_flags mis=%b berr=%b want %b/0", t, o.mis, o.berr, mis);
            end
            if (mis || !we) begin
                n_tests++;
                if (o.ld !== (mis ? 32'h0 : m_load(size, uns, addr, rdata))) begin
                    n_fail++; $display("FAIL rnd%0d_load got %h want %h", t, o.ld,
                                       mis ? 32'h0 : m_load(size, uns, addr, rdata));
                end
            end
            n_tests++;
            if (o.req_seen !== !mis) begin
                n_fail++; $display("FAIL rnd%0d_req_seen got %b want %b", t, o.req_seen, !mis);
            end
            if (!mis) begin
                n_tests++;
                if ({o.addr, o.be, o.we} !== {addr & 32'hFFFF_FFFC, m_be(size, addr), we}) begin
                    n_fail++; $display("FAIL rnd%0d_bus addr=%h be=%b we=%b want %h/%b/%b", t, o.addr, o.be, o.we,
                                       addr & 32'hFFFF_FFFC, m_be(size, addr), we);
                end
                if (we) begin
                    n_tests++;
                    if (o.wdata !== m_wdata(size, sdata)) begin
                        n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", t, o.wdata, m_wdata(size, sdata));
                    end
                end
            end
            n_tests++;
            if ({o.stall_ok, o.done_stall} !== 2'b10) begin
                n_fail++; $display("FAIL rnd%0d_stall ok=%b at_done=%b want 1/0", t, o.stall_ok, o.done_stall);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata = '0;
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store();
        test_misalign();
        test_timeout();
        test_collide_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
